matrix_loader: RTL
==================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 24, Avalon master byte-address width.
REQ-002 Parameter MAX_DIMENSION, default 32, largest accepted matrix side.
REQ-003 Parameter MAX_OUTSTANDING, default 8, maximum in-flight read transactions.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle load request.
REQ-008 base_addr  in  ADDR_WIDTH  byte address of element [0][0]; row-major, 4 bytes per element.
REQ-009 dimension  in  6  matrix side N.
REQ-010 busy  out  1  high from an accepted start until the done pulse, inclusive.
REQ-011 done  out  1  one-cycle pulse: all N*N words are written to RAM.
REQ-012 error  out  1  one-cycle pulse: start rejected for an invalid dimension.
REQ-013 avm_address  out  ADDR_WIDTH  Avalon read address.
REQ-014 avm_read  out  1  Avalon read request.
REQ-015 avm_readdata  in  32  Avalon read data.
REQ-016 avm_readdatavalid  in  1  Avalon read data valid.
REQ-017 avm_waitrequest  in  1  Avalon stall.
REQ-018 ram_wraddress  out  10  RAM write address.
REQ-019 ram_data  out  32  RAM write data.
REQ-020 ram_wren  out  1  RAM write enable.

Function
REQ-021 Total word count T = N*N shall be computed at 11-bit width (maximum 1024).
REQ-022 FSM states shall be IDLE, ISSUE, DRAIN and FINISH.
REQ-023 IDLE with start and 2<=N<=MAX_DIMENSION: latch base_addr and N, clear counters, go to ISSUE, assert busy next cycle.
REQ-024 IDLE with start and N<2 or N>MAX_DIMENSION: pulse error for exactly one cycle the next cycle and stay in IDLE.
REQ-025 start outside IDLE shall be ignored, with no effect on state, counters or outputs.
REQ-026 ISSUE shall hold avm_read high while issued<T and outstanding<MAX_OUTSTANDING; otherwise avm_read shall be low.
REQ-027 A read is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-028 On acceptance: issued+1, avm_address+4.
REQ-029 avm_address and avm_read shall stay stable while avm_waitrequest=1.
REQ-030 First address = latched base; last address = base+4*(T-1).
REQ-031 outstanding shall increment on acceptance and decrement on readdatavalid; on the same cycle it shall be unchanged. It shall never exceed MAX_OUTSTANDING.
REQ-032 On readdatavalid (any state except IDLE): next cycle ram_wren=1, ram_data=avm_readdata, ram_wraddress=received; then received+1. Otherwise ram_wren=0 next cycle.
REQ-033 ISSUE shall go to DRAIN when issued reaches T; avm_read shall be low in DRAIN.
REQ-034 DRAIN shall go to FINISH on the cycle the T-th word's RAM write is presented.
REQ-035 FINISH shall pulse done for one cycle, deassert busy on the next cycle, and return to IDLE.
REQ-036 readdatavalid in IDLE shall be ignored, with no RAM write.
REQ-037 Back-to-back operation: a valid start in the cycle after done shall be accepted.

Reset
REQ-038 reset_n low shall asynchronously force state IDLE, all counters to 0, and busy, done, error, avm_read, ram_wren, avm_address, ram_wraddress and ram_data to 0.
REQ-039 Reset mid-load shall abandon in-flight reads; their late readdatavalid beats arrive in IDLE and shall be discarded.

Verification
REQ-040 N=3, base 0x000100, waitrequest=0, readdatavalid 2 cycles after acceptance -> addresses 0x100..0x120, 9 RAM writes to addresses 0..8 with matching data, single done pulse, busy low after done.
REQ-041 N=32, readdatavalid withheld -> exactly 8 reads issued, then avm_read=0; releasing readdatavalid resumes issue; 1024 writes, last ram_wraddress=1023.
REQ-042 N=4 with random waitrequest -> avm_address and avm_read stable under stall, no duplicate or skipped address, 16 writes.
REQ-043 start with dimension=1, then with dimension=33 -> one error pulse each, avm_read never asserted, busy stays 0.
REQ-044 reset_n low after 5 of 9 reads accepted, then 4 stray readdatavalid beats -> all outputs 0, ram_wren stays 0, next valid start completes normally.
REQ-045 Second start issued while busy -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - Streams an N x N row-major matrix from an Avalon master port into a local RAM.
module matrix_loader #(
    parameter int ADDR_WIDTH      = 24,
    parameter int MAX_DIMENSION   = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [5:0]            dimension,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest,
    output logic [9:0]            ram_wraddress,
    output logic [31:0]           ram_data,
    output logic                  ram_wren
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [6:0]    MAX_DIM = 7'(MAX_DIMENSION);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t          r_state;
    logic [5:0]      r_dim;
    logic [10:0]     r_issued;
    logic [10:0]     r_received;
    logic [OW-1:0]   r_outstanding;

    logic [10:0]     w_total;
    logic            w_accept;
    logic            w_rdv;
    logic            w_dim_ok;
    logic [10:0]     w_issued_nxt;
    logic [OW-1:0]   w_outst_nxt;

    assign w_total      = {5'd0, r_dim} * {5'd0, r_dim};
    assign w_accept     = (r_state == S_ISSUE) && avm_read && !avm_waitrequest;
    // Beats arriving in IDLE belong to an abandoned load and are dropped.
    assign w_rdv        = avm_readdatavalid && (r_state != S_IDLE);
    assign w_dim_ok     = (dimension >= 6'd2) && ({1'b0, dimension} <= MAX_DIM);
    assign w_issued_nxt = r_issued + {10'd0, w_accept};
    assign w_outst_nxt  = r_outstanding + OW'(w_accept) - OW'(w_rdv);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_dim         <= '0;
            r_issued      <= '0;
            r_received    <= '0;
            r_outstanding <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            ram_wraddress <= '0;
            ram_data      <= '0;
            ram_wren      <= 1'b0;
        end else begin
            done     <= 1'b0;
            error    <= 1'b0;
            ram_wren <= 1'b0;

            if (w_rdv) begin
                ram_wren      <= 1'b1;
                ram_data      <= avm_readdata;
                ram_wraddress <= r_received[9:0];
                r_received    <= r_received + 11'd1;
            end

            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        if (w_dim_ok) begin
                            r_dim         <= dimension;
                            r_issued      <= '0;
                            r_received    <= '0;
                            r_outstanding <= '0;
                            avm_address   <= base_addr;
                            avm_read      <= 1'b1;
                            busy          <= 1'b1;
                            r_state       <= S_ISSUE;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_issued      <= w_issued_nxt;
                    r_outstanding <= w_outst_nxt;
                    if (w_accept)
                        avm_address <= avm_address + ADDR_WIDTH'(4);
                    // avm_read is registered, so it is derived from next-cycle counters.
                    if (w_issued_nxt == w_total) begin
                        avm_read <= 1'b0;
                        r_state  <= S_DRAIN;
                    end else begin
                        avm_read <= (w_outst_nxt < MAX_OUT);
                    end
                end
                S_DRAIN: begin
                    r_outstanding <= w_outst_nxt;
                    if (w_rdv && (r_received + 11'd1 == w_total))
                        r_state <= S_FINISH;
                end
                S_FINISH: begin
                    r_outstanding <= w_outst_nxt;
                    done          <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
